// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared lamp encodings, phase codes and lamp decode helpers
package traffic_pkg;

    localparam int LAMP_W = 3;

    typedef logic [0:LAMP_W-1] lamp_t;

    localparam lamp_t RED    = 3'b100;
    localparam lamp_t GREEN  = 3'b010;
    localparam lamp_t YELLOW = 3'b001;

    typedef enum logic [2:0] {
        MAIN_G   = 3'd0,
        MAIN_Y   = 3'd1,
        ALLRED_A = 3'd2,
        WALK     = 3'd3,
        SIDE_G   = 3'd4,
        SIDE_Y   = 3'd5,
        ALLRED_B = 3'd6
    } phase_e;

    function automatic lamp_t main_lamp(input phase_e s);
        case (s)
            MAIN_G:  main_lamp = GREEN;
            MAIN_Y:  main_lamp = YELLOW;
            default: main_lamp = RED;
        endcase
    endfunction

    function automatic lamp_t side_lamp(input phase_e s);
        case (s)
            SIDE_G:  side_lamp = GREEN;
            SIDE_Y:  side_lamp = YELLOW;
            default: side_lamp = RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - down-counter that measures phase length in tick_en strobes
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             tick_en,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // The owner drives load during reset, so no separate reset path is needed here.
    always_ff @(posedge clock) begin
        if (load) begin
            count <= load_value;
        end else if (tick_en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = tick_en && (count == '0);

endmodule

// File: rtl/traffic_phase_controller.sv
// rtl/traffic_phase_controller.sv - two-road lamp scheduler with all-red clearance and pedestrian walk
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 5,
    parameter int CNT_W        = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tick_en,
    input  logic        ped_req,
    output logic        ped_ack,
    output logic [0:2]  main_light,
    output logic [0:2]  side_light,
    output logic        walk,
    output logic [2:0]  phase
);

    phase_e           state;
    phase_e           next_state;
    logic             done;
    logic             load;
    logic [CNT_W-1:0] load_value;
    logic             ped_pending;
    logic             accept;
    logic             entering_walk;

    function automatic logic [CNT_W-1:0] duration(input phase_e s);
        case (s)
            MAIN_G, SIDE_G: duration = CNT_W'(GREEN_TICKS - 1);
            MAIN_Y, SIDE_Y: duration = CNT_W'(YELLOW_TICKS - 1);
            WALK:           duration = CNT_W'(WALK_TICKS - 1);
            default:        duration = CNT_W'(ALLRED_TICKS - 1);
        endcase
    endfunction

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clock      (clock),
        .load       (load),
        .load_value (load_value),
        .tick_en    (tick_en),
        .done       (done)
    );

    always_comb begin
        next_state = state;
        case (state)
            MAIN_G:   if (done) next_state = MAIN_Y;
            MAIN_Y:   if (done) next_state = ALLRED_A;
            ALLRED_A: if (done) next_state = ped_pending ? WALK : SIDE_G;
            WALK:     if (done) next_state = SIDE_G;
            SIDE_G:   if (done) next_state = SIDE_Y;
            SIDE_Y:   if (done) next_state = ALLRED_B;
            ALLRED_B: if (done) next_state = MAIN_G;
            default:  next_state = ALLRED_B;
        endcase
    end

    // Every state change reloads the timer with the duration of the state being entered.
    always_comb begin
        load       = !reset_n || (next_state != state);
        load_value = reset_n ? duration(next_state) : CNT_W'(ALLRED_TICKS - 1);
    end

    always_comb begin
        entering_walk = (next_state == WALK) && (state != WALK);
        accept        = ped_req && !ped_pending && (state != WALK);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= ALLRED_B;
            main_light  <= RED;
            side_light  <= RED;
            walk        <= 1'b0;
            ped_pending <= 1'b0;
            ped_ack     <= 1'b0;
        end else begin
            state       <= next_state;
            main_light  <= main_lamp(next_state);
            side_light  <= side_lamp(next_state);
            walk        <= (next_state == WALK);
            ped_ack     <= accept && !entering_walk;
            if (entering_walk) begin
                ped_pending <= 1'b0;
            end else if (accept) begin
                ped_pending <= 1'b1;
            end
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb/tb_traffic_phase_controller.sv - randomized self-checking bench against a phase-table model
module tb_traffic_phase_controller;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_en = 1'b0;
    logic       ped_req = 1'b0;
    logic       ped_ack;
    logic [0:2] main_light;
    logic [0:2] side_light;
    logic       walk;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    int m_state = 6;
    int m_elapsed = 0;
    bit m_pend = 1'b0;
    bit m_ack = 1'b0;
    int dur [7] = '{8, 3, 1, 5, 8, 3, 1};

    traffic_phase_controller dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .tick_en    (tick_en),
        .ped_req    (ped_req),
        .ped_ack    (ped_ack),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .phase      (phase)
    );

    always #5 clock = ~clock;

    function automatic logic [0:2] exp_main(input int s);
        if (s == 0) return 3'b010;
        if (s == 1) return 3'b001;
        return 3'b100;
    endfunction

    function automatic logic [0:2] exp_side(input int s);
        if (s == 4) return 3'b010;
        if (s == 5) return 3'b001;
        return 3'b100;
    endfunction

    function automatic bit onehot3(input logic [0:2] v);
        return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
    endfunction

    task automatic model_step();
        bit accept;
        bit leave;
        int nxt;
        if (!reset_n) begin
            m_state = 6; m_elapsed = 0; m_pend = 1'b0; m_ack = 1'b0;
        end else begin
            accept = ped_req && !m_pend && (m_state != 3);
            leave  = tick_en && (m_elapsed + 1 == dur[m_state]);
            nxt    = m_state;
            if (leave) begin
                if (m_state == 2) nxt = m_pend ? 3 : 4;
                else if (m_state == 6) nxt = 0;
                else nxt = m_state + 1;
                m_elapsed = 0;
            end else if (tick_en) begin
                m_elapsed++;
            end
            m_ack = accept && !(leave && nxt == 3);
            if (leave && nxt == 3) m_pend = 1'b0;
            else if (accept) m_pend = 1'b1;
            m_state = nxt;
        end
    endtask

    task automatic cycle(input bit rst, input bit tk, input bit rq);
        logic [10:0] got;
        logic [10:0] want;
        bit bad;
        reset_n = rst; tick_en = tk; ped_req = rq;
        @(posedge clock);
        model_step();
        #1;
        got  = {main_light, side_light, walk, ped_ack, phase};
        want = {exp_main(m_state), exp_side(m_state), (m_state == 3), m_ack, 3'(m_state)};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL outputs t=%0t got main=%b side=%b walk=%b ack=%b phase=%0d want main=%b side=%b walk=%b ack=%b phase=%0d",
                     $time, main_light, side_light, walk, ped_ack, phase,
                     want[10:8], want[7:5], want[4], want[3], want[2:0]);
        end
        bad = !onehot3(main_light) || !onehot3(side_light)
           || ((main_light != 3'b100) && ((side_light != 3'b100) || walk))
           || ((side_light != 3'b100) && ((main_light != 3'b100) || walk));
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL invariant t=%0t main=%b side=%b walk=%b required exclusive one-hot lamps",
                     $time, main_light, side_light, walk);
        end
        @(negedge clock);
    endtask

    task automatic wait_state(input int s, input int limit);
        int n = 0;
        while (m_state != s && n < limit) begin
            cycle(1, 1, 0);
            n++;
        end
        checks++;
        if (m_state != s) begin
            errors++;
            $display("FAIL wait_state timeout reached=%0d required=%0d", m_state, s);
        end
    endtask

    task automatic test_reset();
        int prev = 6;
        int first = -1;
        int period = -1;
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        for (int i = 0; i < 60; i++) begin
            cycle(1, 1, 0);
            if (phase == 3'd0 && prev != 0) begin
                if (first < 0) first = i;
                else if (period < 0) period = i - first;
            end
            prev = int'(phase);
        end
        checks++;
        if (period != 24) begin
            errors++;
            $display("FAIL period got=%0d required=24", period);
        end
    endtask

    task automatic test_ped_pulse();
        int acks = 0;
        int walks = 0;
        wait_state(0, 40);
        cycle(1, 1, 1);
        if (ped_ack) acks++;
        for (int i = 0; i < 40; i++) begin
            cycle(1, 1, 0);
            if (ped_ack) acks++;
            if (walk) walks++;
        end
        checks++;
        if (acks != 1 || walks != 5) begin
            errors++;
            $display("FAIL ped_pulse acks=%0d walks=%0d required 1 and 5", acks, walks);
        end
    endtask

    task automatic test_ped_held();
        int acks = 0;
        int walks = 0;
        wait_state(0, 40);
        for (int i = 0; i < 30; i++) begin
            cycle(1, 1, 1);
            if (ped_ack) acks++;
            if (walk) walks++;
        end
        checks++;
        if (acks != 2 || walks != 5) begin
            errors++;
            $display("FAIL ped_held acks=%0d walks=%0d required 2 and 5", acks, walks);
        end
        for (int i = 0; i < 60; i++) cycle(1, 1, 0);
    endtask

    task automatic test_tick_sparse();
        int run = 0;
        int measured = -1;
        bit started = 1'b0;
        int prev = int'(phase);
        for (int i = 0; i < 220; i++) begin
            cycle(1, (i % 4) == 0, ($urandom_range(0, 7) == 0));
            if (phase == 3'd0) begin
                if (prev != 0) begin started = 1'b1; run = 0; end
                run++;
            end else if (prev == 0 && started && measured < 0) begin
                measured = run;
            end
            prev = int'(phase);
        end
        checks++;
        if (measured != 32) begin
            errors++;
            $display("FAIL sparse_main_g_len got=%0d required=32", measured);
        end
    endtask

    task automatic test_freeze();
        wait_state(5, 60);
        for (int i = 0; i < 20; i++) cycle(1, 0, 0);
        checks++;
        if (phase !== 3'd5 || side_light !== 3'b001 || main_light !== 3'b100) begin
            errors++;
            $display("FAIL freeze phase=%0d main=%b side=%b required 5 100 001", phase, main_light, side_light);
        end
        for (int i = 0; i < 10; i++) cycle(1, 1, 0);
    endtask

    task automatic test_reset_mid_walk();
        int n = 0;
        bit main_first = 1'b0;
        bit seen = 1'b0;
        wait_state(0, 40);
        cycle(1, 1, 1);
        wait_state(3, 40);
        cycle(1, 1, 0);
        cycle(1, 1, 0);
        cycle(0, 1, 0);
        checks++;
        if (main_light !== 3'b100 || side_light !== 3'b100 || walk !== 1'b0 || ped_ack !== 1'b0 || phase !== 3'd6) begin
            errors++;
            $display("FAIL reset_mid_walk main=%b side=%b walk=%b ack=%b phase=%0d required 100 100 0 0 6",
                     main_light, side_light, walk, ped_ack, phase);
        end
        while (!seen && n < 30) begin
            cycle(1, 1, 0);
            if (main_light == 3'b010) begin seen = 1'b1; main_first = 1'b1; end
            else if (side_light == 3'b010) seen = 1'b1;
            n++;
        end
        checks++;
        if (!main_first) begin
            errors++;
            $display("FAIL first_green_after_reset main_first=%0b required=1", main_first);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0));
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_ped_pulse();
        test_ped_held();
        test_tick_sparse();
        test_freeze();
        test_reset_mid_walk();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
